// File: rtl/tri_vertex_bank_if.sv
// Host write port of the vertex bank: coordinate writes, commit request and status.
interface tri_vertex_bank_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [11:0] wr_data;
    logic        commit;
    logic        pending;
    logic        err;

    modport master (
        output wr_valid, wr_idx, wr_data, commit,
        input  wr_ready, pending, err
    );

    modport slave (
        input  wr_valid, wr_idx, wr_data, commit,
        output wr_ready, pending, err
    );
endinterface

// File: rtl/tri_vertex_bank.sv
// Frame-synchronised triangle vertex bank: shadow writes, commit, swap on frame_start.
// Optional macro VERTEX_ANIM_EN adds a bouncing (dx,dy) offset to the outputs.
module tri_vertex_bank #(
    parameter logic [11:0] H_MIN  = 12'd285,
    parameter logic [11:0] H_MAX  = 12'd1554,
    parameter logic [11:0] V_MIN  = 12'd35,
    parameter logic [11:0] V_MAX  = 12'd514,
    parameter logic [11:0] X1_RST = 12'd286,
    parameter logic [11:0] Y1_RST = 12'd36,
    parameter logic [11:0] X2_RST = 12'd300,
    parameter logic [11:0] Y2_RST = 12'd300,
    parameter logic [11:0] X3_RST = 12'd1000,
    parameter logic [11:0] Y3_RST = 12'd500
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                frame_start,
    tri_vertex_bank_if.slave    host,
    output logic [11:0]         x1,
    output logic [11:0]         y1,
    output logic [11:0]         x2,
    output logic [11:0]         y2,
    output logic [11:0]         x3,
    output logic [11:0]         y3
);
    typedef enum logic {IDLE, PEND} state_t;

    state_t      state_q, state_d;
    logic [11:0] shadow_q [6];
    logic [11:0] active_q [6];
    logic        err_q;
    logic        wr_fire;
    logic        wr_legal;
    logic        swap;

    function automatic logic [11:0] rst_val(input int i);
        case (i)
            0:       return X1_RST;
            1:       return Y1_RST;
            2:       return X2_RST;
            3:       return Y2_RST;
            4:       return X3_RST;
            default: return Y3_RST;
        endcase
    endfunction

    always_comb begin
        wr_legal = 1'b0;
        case (host.wr_idx)
            3'd0, 3'd2, 3'd4: wr_legal = (host.wr_data >= H_MIN) && (host.wr_data <= H_MAX);
            3'd1, 3'd3, 3'd5: wr_legal = (host.wr_data >= V_MIN) && (host.wr_data <= V_MAX);
            default:          wr_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        host.wr_ready = 1'b0;
        host.pending  = 1'b0;
        swap          = 1'b0;
        case (state_q)
            IDLE: begin
                host.wr_ready = 1'b1;
                if (host.commit) state_d = PEND;
            end
            PEND: begin
                host.pending = 1'b1;
                if (frame_start) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_fire  = host.wr_valid && (state_q == IDLE);
    assign host.err = err_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= rst_val(i);
                active_q[i] <= rst_val(i);
            end
        end else begin
            state_q <= state_d;
            if (wr_fire && !wr_legal) err_q <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (wr_fire && wr_legal && (host.wr_idx == 3'(i))) shadow_q[i] <= host.wr_data;
                // Swap publishes the pre-edge shadow; a write cannot coincide since PEND stalls writes.
                if (swap) active_q[i] <= shadow_q[i];
            end
        end
    end

`ifdef VERTEX_ANIM_EN
    logic signed [11:0] dx_q, dy_q, dx_step, dy_step;
    logic               dir_x_q, dir_y_q;
    logic               x_out, y_out;

    function automatic logic leaves(input logic [11:0] v, input logic signed [11:0] off,
                                    input logic [11:0] lo, input logic [11:0] hi);
        logic signed [13:0] s;
        s = $signed({2'b00, v}) + $signed({{2{off[11]}}, off});
        return (s < $signed({2'b00, lo})) || (s > $signed({2'b00, hi}));
    endfunction

    always_comb begin
        dx_step = dir_x_q ? dx_q + 12'sd1 : dx_q - 12'sd1;
        dy_step = dir_y_q ? dy_q + 12'sd1 : dy_q - 12'sd1;
        x_out   = leaves(active_q[0], dx_step, H_MIN, H_MAX) ||
                  leaves(active_q[2], dx_step, H_MIN, H_MAX) ||
                  leaves(active_q[4], dx_step, H_MIN, H_MAX);
        y_out   = leaves(active_q[1], dy_step, V_MIN, V_MAX) ||
                  leaves(active_q[3], dy_step, V_MIN, V_MAX) ||
                  leaves(active_q[5], dy_step, V_MIN, V_MAX);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            dx_q    <= '0;
            dy_q    <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else if (swap) begin
            dx_q    <= '0;
            dy_q    <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else if ((state_q == IDLE) && frame_start) begin
            // An axis that would leave the visible window bounces and holds for this frame.
            if (x_out) dir_x_q <= ~dir_x_q;
            else       dx_q    <= dx_step;
            if (y_out) dir_y_q <= ~dir_y_q;
            else       dy_q    <= dy_step;
        end
    end

    assign x1 = active_q[0] + dx_q;
    assign y1 = active_q[1] + dy_q;
    assign x2 = active_q[2] + dx_q;
    assign y2 = active_q[3] + dy_q;
    assign x3 = active_q[4] + dx_q;
    assign y3 = active_q[5] + dy_q;
`else
    assign x1 = active_q[0];
    assign y1 = active_q[1];
    assign x2 = active_q[2];
    assign y2 = active_q[3];
    assign x3 = active_q[4];
    assign y3 = active_q[5];
`endif

endmodule

// File: tb/tb_tri_vertex_bank.sv
// Self-checking bench for tri_vertex_bank (default build): directed cases then random traffic.
module tb_tri_vertex_bank;
    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic        frame_start;
    logic [11:0] x1, y1, x2, y2, x3, y3;

    tri_vertex_bank_if bus ();

    tri_vertex_bank dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .frame_start (frame_start),
        .host        (bus),
        .x1          (x1),
        .y1          (y1),
        .x2          (x2),
        .y2          (y2),
        .x3          (x3),
        .y3          (y3)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    int m_sh  [6];
    int m_act [6];
    bit m_pend;
    bit m_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int idx, input int d);
        if (idx > 5) return 1'b0;
        if (idx % 2 == 0) return (d >= 285) && (d <= 1554);
        return (d >= 35) && (d <= 514);
    endfunction

    task automatic model_reset();
        m_sh   = '{286, 36, 300, 300, 1000, 500};
        m_act  = '{286, 36, 300, 300, 1000, 500};
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x1"}, int'(x1), m_act[0]);
        chk({tag, ".y1"}, int'(y1), m_act[1]);
        chk({tag, ".x2"}, int'(x2), m_act[2]);
        chk({tag, ".y2"}, int'(y2), m_act[3]);
        chk({tag, ".x3"}, int'(x3), m_act[4]);
        chk({tag, ".y3"}, int'(y3), m_act[5]);
        chk({tag, ".wr_ready"}, int'(bus.wr_ready), int'(!m_pend));
        chk({tag, ".pending"}, int'(bus.pending), int'(m_pend));
        chk({tag, ".err"}, int'(bus.err), int'(m_err));
    endtask

    // One clock of host/timing stimulus; the model advances on the same edge.
    task automatic step(input bit v, input int idx, input int d, input bit c, input bit fs,
                        input string tag);
        @(negedge CLOCK_50);
        bus.wr_valid = v;
        bus.wr_idx   = 3'(idx);
        bus.wr_data  = 12'(d);
        bus.commit   = c;
        frame_start  = fs;
        @(posedge CLOCK_50);
        if (!m_pend) begin
            if (v) begin
                if (legal(idx, d)) m_sh[idx] = d;
                else               m_err = 1'b1;
            end
            if (c) m_pend = 1'b1;
        end else if (fs) begin
            m_act  = m_sh;
            m_pend = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, "idle");
    endtask

    initial begin
        RESET        = 1'b1;
        frame_start  = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_idx   = '0;
        bus.wr_data  = '0;
        bus.commit   = 1'b0;
        model_reset();
        #23;
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check_all("reset");
        chk("reset.x3_const", int'(x3), 1000);

        // Write and commit
        step(1, 0, 400, 0, 0, "wr_x1");
        step(1, 5, 480, 0, 0, "wr_y3");
        step(0, 0, 0, 1, 0, "commit");
        chk("commit.pending", int'(bus.pending), 1);
        chk("commit.wr_ready", int'(bus.wr_ready), 0);
        idle(3);
        chk("hold.x1", int'(x1), 286);
        step(1, 1, 100, 0, 0, "stall_wr");
        step(0, 0, 0, 0, 1, "swap1");
        chk("swap1.x1", int'(x1), 400);
        chk("swap1.y3", int'(y3), 480);
        chk("swap1.pending", int'(bus.pending), 0);

        // Rejected writes
        step(1, 2, 100, 0, 0, "rej_x2");
        chk("rej.err", int'(bus.err), 1);
        step(1, 6, 500, 0, 0, "rej_idx6");
        step(0, 0, 0, 1, 0, "commit2");
        step(0, 0, 0, 0, 1, "swap2");
        chk("rej.x2_kept", int'(x2), 300);
        chk("rej.err_sticky", int'(bus.err), 1);

        // commit with frame_start in the same cycle
        step(1, 0, 500, 0, 0, "wr_x1b");
        step(0, 0, 0, 1, 1, "commit_fs");
        chk("commit_fs.no_swap", int'(x1), 400);
        chk("commit_fs.pending", int'(bus.pending), 1);
        idle(2);
        step(0, 0, 0, 0, 1, "swap3");
        chk("swap3.x1", int'(x1), 500);

        // write with commit in the same cycle
        step(1, 1, 200, 1, 0, "wr_commit");
        step(0, 0, 0, 0, 1, "swap4");
        chk("swap4.y1", int'(y1), 200);

        // Reset while pending
        step(1, 0, 600, 1, 0, "pend_again");
        @(negedge CLOCK_50);
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b0;
        RESET        = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge CLOCK_50);
        RESET = 1'b0;
        step(0, 0, 0, 0, 1, "fs_after_rst");
        chk("fs_after_rst.x1", int'(x1), 286);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int idx, d;
            bit v, c, fs;
            v   = ($urandom_range(0, 1) == 1);
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0)
                d = (idx % 2 == 0) ? $urandom_range(285, 1554) : $urandom_range(35, 514);
            else
                d = $urandom_range(0, 4095);
            c  = ($urandom_range(0, 7) == 0);
            fs = ($urandom_range(0, 5) == 0);
            step(v, idx, d, c, fs, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tri_vertex_bank.md
# tri_vertex_bank

Frame-synchronised vertex register bank that supplies the three triangle vertices (x1,y1,x2,y2,x3,y3) to the point-in-triangle coverage stage of the VGA triangle renderer. A host writes new coordinates into a shadow bank through a valid/ready port, then requests a commit. The shadow bank is copied to the active outputs only on the frame-start pulse from the VGA timing counter, so a frame never mixes old and new vertices.

## Interface
Parameters:
- H_MIN, 285, first visible horizontal counter value
- H_MAX, 1554, last visible horizontal counter value
- V_MIN, 35, first visible vertical counter value
- V_MAX, 514, last visible vertical counter value
- X1_RST/Y1_RST/X2_RST/Y2_RST/X3_RST/Y3_RST, 286/36/300/300/1000/500, reset vertex coordinates

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- RESET  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse when the timing counter wraps (cx==1585 and cy==525)
- wr_valid  in  1  host write request
- wr_ready  out  1  bank accepts a write this cycle
- wr_idx  in  3  target: 0=x1, 1=y1, 2=x2, 3=y2, 4=x3, 5=y3; 6 and 7 are illegal
- wr_data  in  12  coordinate value
- commit  in  1  one-cycle request to publish the shadow bank
- pending  out  1  commit accepted, waiting for frame_start
- err  out  1  sticky; set by any rejected write
- x1, y1, x2, y2, x3, y3  out  12 each  active vertices, registered

## Operation
- FSM states:
  - IDLE: wr_ready=1; pending=0.
  - PEND: wr_ready=0; pending=1.
- IDLE transitions:
  - A write handshake (wr_valid & wr_ready) updates shadow[wr_idx] at the clock edge.
  - A write on the same cycle as commit is accepted and included in the commit.
  - commit moves IDLE→PEND.
- PEND transitions:
  - frame_start copies all six shadow registers to the active outputs and moves PEND→IDLE.
  - commit while in PEND is ignored.
  - wr_valid while in PEND is stalled, not dropped: the host holds it.
- Range check on every handshake:
  - x indices (0,2,4) require H_MIN ≤ wr_data ≤ H_MAX.
  - y indices (1,3,5) require V_MIN ≤ wr_data ≤ V_MAX.
  - wr_idx 6/7 is always illegal.
  - A rejected write completes its handshake, leaves shadow unchanged and sets err.
  - err clears only on RESET.
- Simultaneous events:
  - commit and frame_start in the same cycle while in IDLE: enter PEND; the swap waits for the next frame_start.
  - frame_start in IDLE with no commit: no effect.
- Degenerate triangles (collinear or coincident vertices) are legal and are not checked.

## Timing
- Reset values:
  - State IDLE; pending=0; err=0; wr_ready=1.
  - Shadow and active registers equal the *_RST parameters.
  - With the animation feature compiled in, the offset is 0 and its direction is (+1,+1).
- Write latency: the shadow register updates at the accepting edge. It is not visible on the outputs until a swap.
- Swap latency:
  - Outputs change at the edge where frame_start=1 is sampled in PEND.
  - All six outputs change on the same edge.
  - Commit-to-visible worst case is one full frame (1586×526 cycles).
- pending deasserts on the swap edge. wr_ready reasserts on that same edge.
- RESET asserted mid-operation (in PEND or mid-write): all registers return to reset values immediately. The pending commit is discarded.
- Outputs are stable for the whole active region of a frame.

## Configuration
- Macro VERTEX_ANIM_EN.
- When defined, adds signed 12-bit offsets dx and dy.
  - Outputs become active + offset.
  - On each frame_start in IDLE, dx moves ±1 and dy moves ±1 in the current direction.
  - An axis direction reverses, and that axis's offset holds for that frame, when any vertex plus the new offset would leave [H_MIN,H_MAX] or [V_MIN,V_MAX].
  - Each swap resets the offset to 0 and the direction to (+1,+1).
- When undefined, outputs equal the active registers exactly and no offset logic is synthesised.

## Test plan
- Reset check: assert RESET, release. Required: outputs 286/36/300/300/1000/500; wr_ready=1; pending=0; err=0.
- Write and commit: write x1=400 and y3=480, then pulse commit. Required:
  - pending=1 and wr_ready=0 on the next cycle.
  - Outputs unchanged until frame_start.
  - On the frame_start edge, x1=400 and y3=480; pending=0.
- Rejected writes: write x2=100 (below H_MIN), then wr_idx=6. Required: both handshakes complete; x2 shadow stays 300; err=1 until RESET.
- Same-cycle events:
  - commit with frame_start in the same cycle. Required: no swap on that frame; swap at the next frame_start.
  - Write with commit in the same cycle. Required: the written value appears after the swap.
- Reset while pending: assert RESET while pending=1. Required: outputs return to reset values; the next frame_start causes no change.
- Animation (VERTEX_ANIM_EN): after 10 frame_starts with no commit, x1=296 and y1=46. Run until x3 reaches 1554; on the next frame dx reverses direction.
